// File: rtl/reset_stretch_sync.sv
// reset_stretch_sync: active-high asynchronous clear for FDCE banks, released only after a synchronised
// reset release, a qualified PLL lock and a programmable stretch. Optional macro: LOCK_LOSS_RESET_EN.
module reset_stretch_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             LOCKED,
  input  logic             SW_RST,
  output logic             CLR,
  output logic             CLR_N,
  output logic             READY,
  output logic [CNT_W-1:0] EVT_CNT
);

  localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SCW-1:0]   CNT_ZERO     = SCW'(0);
  localparam logic [SCW-1:0]   CNT_ONE      = SCW'(1);
  localparam logic [SCW-1:0]   STRETCH_LAST = SCW'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] EVT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rst_pipe_r;
  logic [SYNC_STAGES-1:0] lock_pipe_r;
  logic                   rst_sync_s;
  logic                   lock_sync_s;
  logic                   lock_lost_s;
  state_t                 state_r;
  state_t                 state_nx_s;
  logic [SCW-1:0]         cnt_r;
  logic [SCW-1:0]         cnt_nx_s;
  logic                   exit_run_s;
  logic                   clr_r;
  logic                   clr_n_r;
  logic                   ready_r;
  logic [CNT_W-1:0]       evt_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == EVT_MAX) ? v : v + EVT_ONE;
  endfunction

  // Release synchroniser: clears asynchronously, shifts in a 1 per edge once RST_N is high.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      rst_pipe_r <= {SYNC_STAGES{1'b0}};
    end else begin
      rst_pipe_r <= {rst_pipe_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Lock synchroniser: LOCKED is asynchronous to C.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      lock_pipe_r <= {SYNC_STAGES{1'b0}};
    end else begin
      lock_pipe_r <= {lock_pipe_r[SYNC_STAGES-2:0], LOCKED};
    end
  end

  assign rst_sync_s  = rst_pipe_r[SYNC_STAGES-1];
  assign lock_sync_s = lock_pipe_r[SYNC_STAGES-1];

`ifdef LOCK_LOSS_RESET_EN
  assign lock_lost_s = ~lock_sync_s;
`else
  assign lock_lost_s = 1'b0;
`endif

  // Next-state and stretch-counter logic; lock loss takes priority over a soft reset.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    exit_run_s = 1'b0;
    if (!rst_sync_s) begin
      state_nx_s = WAIT_LOCK;
      cnt_nx_s   = CNT_ZERO;
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          cnt_nx_s = CNT_ZERO;
          if (lock_sync_s) begin
            state_nx_s = STRETCH;
          end else begin
            state_nx_s = WAIT_LOCK;
          end
        end
        STRETCH: begin
          if (lock_lost_s) begin
            state_nx_s = WAIT_LOCK;
            cnt_nx_s   = CNT_ZERO;
          end else if (SW_RST) begin
            state_nx_s = STRETCH;
            cnt_nx_s   = CNT_ZERO;
          end else if (cnt_r == STRETCH_LAST) begin
            state_nx_s = RUN;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s = STRETCH;
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          cnt_nx_s = CNT_ZERO;
          if (lock_lost_s) begin
            state_nx_s = WAIT_LOCK;
            exit_run_s = 1'b1;
          end else if (SW_RST) begin
            state_nx_s = STRETCH;
            exit_run_s = 1'b1;
          end else begin
            state_nx_s = RUN;
          end
        end
        default: begin
          state_nx_s = WAIT_LOCK;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs follow next-state so CLR moves on the transition edge.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= WAIT_LOCK;
      cnt_r     <= CNT_ZERO;
      clr_r     <= 1'b1;
      clr_n_r   <= 1'b0;
      ready_r   <= 1'b0;
      evt_cnt_r <= EVT_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      clr_r   <= (state_nx_s != RUN);
      clr_n_r <= (state_nx_s == RUN);
      ready_r <= (state_nx_s == RUN);
      if (exit_run_s) begin
        evt_cnt_r <= sat_inc(evt_cnt_r);
      end else begin
        evt_cnt_r <= evt_cnt_r;
      end
    end
  end

  assign CLR     = clr_r;
  assign CLR_N   = clr_n_r;
  assign READY   = ready_r;
  assign EVT_CNT = evt_cnt_r;

endmodule

// File: tb/tb_reset_stretch_sync.sv
// Bench for reset_stretch_sync: directed scenarios plus random stimulus, all checked every cycle
// against a phase/remaining-edges model of the release sequence.
module tb_reset_stretch_sync;

  localparam int SYNC = 2;
  localparam int STR  = 16;
  localparam int CW   = 2;
  localparam int EVT_MAX = (1 << CW) - 1;

  logic          c      = 1'b0;
  logic          rst_n  = 1'b1;
  logic          locked = 1'b0;
  logic          sw_rst = 1'b0;
  logic          clr;
  logic          clr_n;
  logic          ready;
  logic [CW-1:0] evt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {M_WAIT, M_STR, M_RUN} mphase_t;
  mphase_t m_phase;
  int      m_rem;
  int      m_evt;
  int      m_rst_edges;
  bit      m_lock_hist[$];

  reset_stretch_sync #(
    .SYNC_STAGES   (SYNC),
    .STRETCH_CYCLES(STR),
    .CNT_W         (CW)
  ) dut (
    .C      (c),
    .RST_N  (rst_n),
    .LOCKED (locked),
    .SW_RST (sw_rst),
    .CLR    (clr),
    .CLR_N  (clr_n),
    .READY  (ready),
    .EVT_CNT(evt_cnt)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase     = M_WAIT;
    m_rem       = 0;
    m_evt       = 0;
    m_rst_edges = 0;
    m_lock_hist = {};
    for (int i = 0; i < SYNC; i++) m_lock_hist.push_back(1'b0);
  endtask

  // One rising edge of the reference: rules evaluated on pre-edge synchronised views.
  task automatic model_edge();
    bit rs;
    bit ls;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rs = (m_rst_edges >= SYNC);
    ls = m_lock_hist[SYNC-1];
    m_lock_hist.push_front(locked);
    void'(m_lock_hist.pop_back());
    if (m_rst_edges < 1000) m_rst_edges++;
    if (!rs) begin
      m_phase = M_WAIT;
    end else begin
      case (m_phase)
        M_WAIT: if (ls) begin m_phase = M_STR; m_rem = STR; end
        M_STR: begin
`ifdef LOCK_LOSS_RESET_EN
          if (!ls) m_phase = M_WAIT;
          else
`endif
          if (sw_rst) m_rem = STR;
          else begin
            m_rem--;
            if (m_rem == 0) m_phase = M_RUN;
          end
        end
        M_RUN: begin
`ifdef LOCK_LOSS_RESET_EN
          if (!ls) begin
            m_phase = M_WAIT;
            if (m_evt < EVT_MAX) m_evt++;
          end else
`endif
          if (sw_rst) begin
            m_phase = M_STR;
            m_rem   = STR;
            if (m_evt < EVT_MAX) m_evt++;
          end
        end
        default: m_phase = M_WAIT;
      endcase
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_clr"},   32'(clr),     (m_phase != M_RUN) ? 1 : 0);
    chk({where, "_clr_n"}, 32'(clr_n),   (m_phase == M_RUN) ? 1 : 0);
    chk({where, "_ready"}, 32'(ready),   (m_phase == M_RUN) ? 1 : 0);
    chk({where, "_evt"},   32'(evt_cnt), m_evt);
  endtask

  // Called just after a falling edge; drives inputs, runs one rising edge, checks, returns at next falling edge.
  task automatic cycle(input logic r, input logic l, input logic s);
    logic dropping;
    dropping = rst_n && !r;
    rst_n  = r;
    locked = l;
    sw_rst = s;
    if (dropping) begin
      #1;
      model_reset();
      check_outputs("async");
    end
    @(posedge c);
    model_edge();
    #1;
    check_outputs("edge");
    @(negedge c);
  endtask

  // Runs up to n edges with fixed inputs and returns the 1-based edge index where CLR first reads 0.
  task automatic release_latency(input int n, input logic l, output int lat);
    lat = -1;
    for (int i = 1; i <= n; i++) begin
      cycle(1'b1, l, 1'b0);
      if (lat < 0 && !clr) lat = i;
    end
  endtask

  initial begin
    int   lat;
    int   sat_tab[5];
    logic r_st;
    logic l_st;
    sat_tab = '{1, 2, 3, 3, 3};

    model_reset();
    #1 rst_n = 1'b0;
    locked = 1'b1;
    #1 check_outputs("por");
    @(negedge c);

    // Power-on release with LOCKED already high.
    repeat (5) cycle(1'b0, 1'b1, 1'b0);
    release_latency(25, 1'b1, lat);
    chk("por_latency", lat, SYNC + 1 + STR);

    // Late lock.
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (27) cycle(1'b1, 1'b0, 1'b0);
    release_latency(25, 1'b1, lat);
    chk("late_lock_latency", lat, SYNC + 1 + STR);

    // Soft reset from RUN, then a second pulse mid-stretch.
    cycle(1'b1, 1'b1, 1'b1);
    chk("soft_clr_edge", 32'(clr), 1);
    release_latency(20, 1'b1, lat);
    chk("soft_latency", lat, STR);
    chk("soft_evt1", 32'(evt_cnt), 1);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (10) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    release_latency(20, 1'b1, lat);
    chk("soft_restretch_latency", lat, STR);

    // Asynchronous reset in RUN, then the full release repeats.
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    release_latency(25, 1'b1, lat);
    chk("async_rerelease_latency", lat, SYNC + 1 + STR);

    // Event counter saturation.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 1'b1);
      repeat (17) cycle(1'b1, 1'b1, 1'b0);
      chk("sat_evt", 32'(evt_cnt), sat_tab[k]);
    end

    // Lock loss coinciding with a soft reset, then plain lock loss.
    cycle(1'b0, 1'b1, 1'b0);
    release_latency(25, 1'b1, lat);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    repeat (25) cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
`ifdef LOCK_LOSS_RESET_EN
    chk("lockloss_clr", 32'(clr), 1);
`else
    chk("lockloss_clr", 32'(clr), 0);
`endif
    repeat (25) cycle(1'b1, 1'b1, 1'b0);

    // Random traffic.
    r_st = 1'b1;
    l_st = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (!r_st) r_st = ($urandom_range(0, 2) == 0);
      else       r_st = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) l_st = ~l_st;
      cycle(r_st, l_st, ($urandom_range(0, 24) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
